// File: rtl/kbd_event_fifo.sv
// ============================================================================
// Module  : kbd_event_fifo
// Brief   : PS/2 set-2 scan-code decoder feeding a show-ahead key event FIFO
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module kbd_event_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  input  logic          rd_en,
  input  logic          clr_ovf,
  output logic [9:0]    rd_data,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          ovf,
  output logic          key_down
);

  localparam logic [AW:0] c_full_cnt  = (AW+1)'(DEPTH);
  localparam logic [7:0]  c_pfx_ext   = 8'hE0;
  localparam logic [7:0]  c_pfx_brk   = 8'hF0;
  localparam logic [7:0]  c_pfx_pause = 8'hE1;
  localparam logic [9:0]  c_ev_pause  = 10'h177;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXT     = 3'd1,
    S_BRK     = 3'd2,
    S_EXT_BRK = 3'd3,
    S_SKIP    = 3'd4
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [2:0]     r_skip, w_skip_nxt;
  logic           w_push;
  logic [9:0]     w_ev;

  logic [9:0]     r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [AW:0]    r_count;
  logic           r_ovf, r_key_down;
  logic           w_full, w_empty, w_pop, w_wr, w_ovf_set;

  logic           w_fake_shift, w_noise;
  assign w_fake_shift = (byte_data == 8'h12) || (byte_data == 8'h59);
  assign w_noise      = (byte_data == 8'h00) || (byte_data == 8'hAA) || (byte_data == 8'hFA) ||
                        (byte_data == 8'hFE) || (byte_data == 8'hFF);

  always_comb begin
    w_state_nxt = r_state;
    w_skip_nxt  = r_skip;
    w_push      = 1'b0;
    w_ev        = '0;
    if (byte_valid) begin
      case (r_state)
        S_IDLE: begin
          if (byte_data == c_pfx_ext) w_state_nxt = S_EXT;
          else if (byte_data == c_pfx_brk) w_state_nxt = S_BRK;
          else if (byte_data == c_pfx_pause) begin
            w_state_nxt = S_SKIP;
            w_skip_nxt  = 3'd7;
          end else if (!w_noise) begin
            w_push = 1'b1;
            w_ev   = {2'b00, byte_data};
          end
        end
        S_EXT: begin
          if (byte_data == c_pfx_brk) w_state_nxt = S_EXT_BRK;
          else if (byte_data == c_pfx_ext) w_state_nxt = S_EXT;
          else begin
            w_state_nxt = S_IDLE;
            w_push      = !w_fake_shift;
            w_ev        = {2'b01, byte_data};
          end
        end
        S_BRK: begin
          w_state_nxt = S_IDLE;
          w_push      = 1'b1;
          w_ev        = {2'b10, byte_data};
        end
        S_EXT_BRK: begin
          w_state_nxt = S_IDLE;
          w_push      = !w_fake_shift;
          w_ev        = {2'b11, byte_data};
        end
        S_SKIP: begin
          // The Pause sequence carries no break code; emit one make on its last byte
          w_skip_nxt = r_skip - 1'b1;
          if (r_skip == 3'd1) begin
            w_state_nxt = S_IDLE;
            w_push      = 1'b1;
            w_ev        = c_ev_pause;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_skip  <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_skip  <= w_skip_nxt;
    end
  end

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == c_full_cnt);
  assign w_pop     = rd_en && !w_empty;
  // A pop frees the slot the full-FIFO push needs, so both proceed
  assign w_wr      = w_push && (!w_full || w_pop);
  assign w_ovf_set = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_ev;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_key_down <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_ovf_set) r_ovf <= 1'b1;
      else if (clr_ovf) r_ovf <= 1'b0;
      if (w_push) r_key_down <= !w_ev[9];
    end
  end

  assign rd_data  = w_empty ? 10'd0 : r_mem[r_rd_ptr];
  assign empty    = w_empty;
  assign count    = r_count;
  assign ovf      = r_ovf;
  assign key_down = r_key_down;

endmodule

`default_nettype wire

// File: tb/tb_kbd_event_fifo.sv
// ============================================================================
// Module  : tb_kbd_event_fifo
// Brief   : Directed self-checking bench for kbd_event_fifo
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_kbd_event_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       rd_en = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [9:0] rd_data;
  logic       empty;
  logic [4:0] count;
  logic       ovf;
  logic       key_down;

  int n_checks = 0;
  int n_fail   = 0;

  kbd_event_fifo #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .rd_en(rd_en), .clr_ovf(clr_ovf), .rd_data(rd_data), .empty(empty),
    .count(count), .ovf(ovf), .key_down(key_down)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic pop();
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rd_data"}, 32'(rd_data), 32'h0);
    check({tag, "_empty"}, 32'(empty), 32'h1);
    check({tag, "_count"}, 32'(count), 32'h0);
    check({tag, "_ovf"}, 32'(ovf), 32'h0);
    check({tag, "_key_down"}, 32'(key_down), 32'h0);
  endtask

  logic [9:0] exp_q[$];

  initial begin
    // Reset
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b1;

    // 1: plain make/break
    send_byte(8'h1C);
    check("t1_kd_make", 32'(key_down), 32'h1);
    send_byte(8'hF0);
    send_byte(8'h1C);
    check("t1_count", 32'(count), 32'd2);
    check("t1_head", 32'(rd_data), 32'h01C);
    check("t1_kd_brk", 32'(key_down), 32'h0);
    pop();
    check("t1_head2", 32'(rd_data), 32'h21C);
    pop();
    check("t1_empty", 32'(empty), 32'h1);
    check("t1_rd0", 32'(rd_data), 32'h0);
    pop();
    check("t1_pop_empty_cnt", 32'(count), 32'd0);

    // 2: extended keys, fake shift dropped
    send_byte(8'hE0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'h12);
    check("t2_count", 32'(count), 32'd2);
    check("t2_head", 32'(rd_data), 32'h175);
    pop();
    check("t2_head2", 32'(rd_data), 32'h375);
    pop();
    check("t2_empty", 32'(empty), 32'h1);

    // 3: noise bytes and Pause sequence
    send_byte(8'hAA); send_byte(8'hFA);
    check("t3_noise", 32'(count), 32'd0);
    send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
    send_byte(8'hF0); send_byte(8'h14);
    check("t3_pause_pending", 32'(count), 32'd0);
    send_byte(8'hF0); send_byte(8'h77);
    check("t3_count", 32'(count), 32'd1);
    check("t3_head", 32'(rd_data), 32'h177);
    pop();
    check("t3_empty", 32'(empty), 32'h1);

    // 4: overflow
    for (int i = 0; i < 17; i++) send_byte(8'h15);
    check("t4_count", 32'(count), 32'd16);
    check("t4_ovf", 32'(ovf), 32'h1);
    check("t4_head", 32'(rd_data), 32'h015);
    @(negedge clk); clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
    check("t4_ovf_clr", 32'(ovf), 32'h0);
    check("t4_count_clr", 32'(count), 32'd16);

    // 5a: push and pop together while full
    @(negedge clk);
    byte_valid = 1'b1; byte_data = 8'h16; rd_en = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0; rd_en = 1'b0;
    check("t5_full_count", 32'(count), 32'd16);
    check("t5_full_ovf", 32'(ovf), 32'h0);
    for (int i = 0; i < 15; i++) pop();
    check("t5_tail", 32'(rd_data), 32'h016);
    check("t5_tail_cnt", 32'(count), 32'd1);
    pop();
    check("t5_drained", 32'(empty), 32'h1);

    // 5b: push and pop together while empty
    @(negedge clk);
    byte_valid = 1'b1; byte_data = 8'h2A; rd_en = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0; rd_en = 1'b0;
    check("t5_empty_count", 32'(count), 32'd1);
    check("t5_empty_head", 32'(rd_data), 32'h02A);
    pop();

    // 5c: streaming through pointer wrap, three events in flight
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        check("t5_wrap", 32'(rd_data), 32'(exp_q[0]));
        rd_en = 1'b1;
        void'(exp_q.pop_front());
      end else begin
        rd_en = 1'b0;
      end
      byte_valid = 1'b1;
      byte_data  = 8'(i + 1);
      exp_q.push_back(10'(i + 1));
    end
    @(negedge clk);
    byte_valid = 1'b0; rd_en = 1'b0;
    check("t5_wrap_cnt", 32'(count), 32'd3);
    while (exp_q.size() > 0) begin
      check("t5_wrap_tail", 32'(rd_data), 32'(exp_q[0]));
      void'(exp_q.pop_front());
      pop();
    end
    check("t5_wrap_empty", 32'(empty), 32'h1);

    // 6: reset mid-sequence discards partial prefix and stored events
    send_byte(8'h33);
    send_byte(8'hE0); send_byte(8'hF0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    check_reset_vals("t6_rst");
    reset = 1'b1;
    send_byte(8'h1C);
    check("t6_count", 32'(count), 32'd1);
    check("t6_head", 32'(rd_data), 32'h01C);
    check("t6_kd", 32'(key_down), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
